// File: rtl/wt_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller with
// 4-word line fills, single-word write-through and saturating hit/miss counters.
module wt_cache_controller #(
  parameter int WIDTH       = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int CACHE_LINES = 32,
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int IW = $clog2(CACHE_LINES),
  localparam int TW = AW - IW - 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [AW-1:0]      cpu_address,
  input  logic               cpu_read,
  input  logic               cpu_write,
  input  logic [WIDTH-1:0]   cpu_write_data,
  output logic [WIDTH-1:0]   cpu_read_data,
  output logic               cpu_ready,
  output logic               cpu_busy,
  output logic [AW-1:0]      mem_address,
  output logic               mem_read_en,
  output logic               mem_write_en,
  output logic [WIDTH-1:0]   mem_write_data,
  input  logic               mem_ready,
  input  logic [4*WIDTH-1:0] mem_read_data,
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL,
    S_FILL_WAIT,
    S_WR_WAIT
  } state_t;

  state_t r_state;

  logic [AW-1:0]          r_addr;
  logic [WIDTH-1:0]       r_wdata;
  logic                   r_is_write;
  logic [1:0]             r_beat;
  logic [CACHE_LINES-1:0] r_valid;
  logic [TW-1:0]          r_tag  [CACHE_LINES];
  logic [WIDTH-1:0]       r_data [CACHE_LINES][4];

  logic [WIDTH-1:0]       r_cpu_read_data;
  logic                   r_cpu_ready;
  logic [AW-1:0]          r_mem_address;
  logic                   r_mem_read_en;
  logic                   r_mem_write_en;
  logic [WIDTH-1:0]       r_mem_write_data;
  logic [15:0]            r_hits;
  logic [15:0]            r_misses;

  logic [TW-1:0]          w_tag;
  logic [IW-1:0]          w_idx;
  logic [1:0]             w_off;
  logic                   w_hit;
  logic                   w_line_fill;
  logic                   w_word_upd;
  logic [WIDTH-1:0]       w_fill_word;

  assign w_tag = r_addr[AW-1 -: TW];
  assign w_idx = r_addr[2 +: IW];
  assign w_off = r_addr[1:0];
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // Array writes are gated by reset so an aborted fill or store never lands.
  assign w_line_fill = !reset && (r_state == S_FILL_WAIT) && mem_ready;
  assign w_word_upd  = !reset && (r_state == S_LOOKUP) && r_is_write && w_hit;
  assign w_fill_word = mem_read_data[32'(w_off) * WIDTH +: WIDTH];

  assign cpu_busy       = (r_state != S_IDLE);
  assign cpu_read_data  = r_cpu_read_data;
  assign cpu_ready      = r_cpu_ready;
  assign mem_address    = r_mem_address;
  assign mem_read_en    = r_mem_read_en;
  assign mem_write_en   = r_mem_write_en;
  assign mem_write_data = r_mem_write_data;
  assign hit_count      = r_hits;
  assign miss_count     = r_misses;

  // Tag and data arrays carry no reset; validity is tracked by r_valid alone.
  always_ff @(posedge clk) begin
    if (w_line_fill) begin
      for (int unsigned k = 0; k < 4; k++) begin
        r_data[w_idx][k[1:0]] <= mem_read_data[k*WIDTH +: WIDTH];
      end
      r_tag[w_idx] <= w_tag;
    end else if (w_word_upd) begin
      r_data[w_idx][w_off] <= r_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_valid          <= '0;
      r_cpu_ready      <= 1'b0;
      r_cpu_read_data  <= '0;
      r_mem_read_en    <= 1'b0;
      r_mem_write_en   <= 1'b0;
      r_mem_address    <= '0;
      r_mem_write_data <= '0;
      r_hits           <= '0;
      r_misses         <= '0;
      r_addr           <= '0;
      r_wdata          <= '0;
      r_is_write       <= 1'b0;
      r_beat           <= '0;
    end else begin
      r_cpu_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_read ^ cpu_write) begin
            r_addr     <= cpu_address;
            r_wdata    <= cpu_write_data;
            r_is_write <= cpu_write;
            r_state    <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (r_is_write) begin
            r_mem_address    <= r_addr;
            r_mem_write_data <= r_wdata;
            r_mem_write_en   <= 1'b1;
            r_state          <= S_WR_WAIT;
          end else if (w_hit) begin
            r_cpu_read_data <= r_data[w_idx][w_off];
            r_cpu_ready     <= 1'b1;
            if (r_hits != 16'hFFFF) r_hits <= r_hits + 16'd1;
            r_state         <= S_IDLE;
          end else begin
            if (r_misses != 16'hFFFF) r_misses <= r_misses + 16'd1;
            r_mem_address <= {w_tag, w_idx, 2'b00};
            r_mem_read_en <= 1'b1;
            r_beat        <= 2'd3;
            r_state       <= S_FILL;
          end
        end

        // Memory counts beats internally: exactly four read_en cycles per line.
        S_FILL: begin
          if (r_beat == 2'd0) begin
            r_mem_read_en <= 1'b0;
            r_state       <= S_FILL_WAIT;
          end else begin
            r_beat <= r_beat - 2'd1;
          end
        end

        S_FILL_WAIT: begin
          if (mem_ready) begin
            r_valid[w_idx]  <= 1'b1;
            r_cpu_read_data <= w_fill_word;
            r_cpu_ready     <= 1'b1;
            r_state         <= S_IDLE;
          end
        end

        S_WR_WAIT: begin
          r_mem_write_en <= 1'b0;
          if (mem_ready) begin
            r_cpu_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
